// File: rtl/alarm_pkg.sv
// Shared alarm definitions: state codes and counter width used by the alarm,
// time counter and display blocks.
package alarm_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_UNUSED  = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: rise is high in the cycle where d is 1 and the
// previously sampled d was 0.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q_r;

  // Sample d once per cycle for the previous-value comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else begin
      q_r <= d;
    end
  end

  assign rise = d & ~q_r;

endmodule

// File: rtl/alarm_controller.sv
// Alarm ring/snooze controller: starts ringing on a rising time match, rings
// for a bounded number of minutes and supports snooze and stop buttons.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eq,
  input  logic       alarm_en,
  input  logic       min_tick,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       snoozing,
  output logic [1:0] state_o
);

  localparam cnt_t SNOOZE_LOAD = cnt_t'(SNOOZE_MIN);
  localparam cnt_t RING_LAST   = cnt_t'(RING_TIMEOUT_MIN - 1);

  alarm_state_e state_r, state_s;
  cnt_t         ring_cnt_r, ring_cnt_s;
  cnt_t         snz_cnt_r, snz_cnt_s;
  logic         match_s;

  edge_detect u_eq_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (eq),
    .rise  (match_s)
  );

  // Next-state and counter update, priorities highest first in each state.
  always_comb begin
    state_s    = state_r;
    ring_cnt_s = ring_cnt_r;
    snz_cnt_s  = snz_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (match_s && alarm_en) begin
          state_s    = ST_RINGING;
          ring_cnt_s = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if (!alarm_en || stop_btn) begin
          state_s = ST_IDLE;
        end else if (snooze_btn) begin
          state_s   = ST_SNOOZE;
          snz_cnt_s = SNOOZE_LOAD;
        end else if (min_tick && (ring_cnt_r >= RING_LAST)) begin
          state_s = ST_IDLE;
        end else if (min_tick) begin
          ring_cnt_s = ring_cnt_r + 4'd1;
        end else begin
          state_s = ST_RINGING;
        end
      end
      ST_SNOOZE: begin
        // Expiry on <=1 keeps the counter from ever wrapping below 1.
        if (!alarm_en || stop_btn) begin
          state_s = ST_IDLE;
        end else if (min_tick && (snz_cnt_r <= 4'd1)) begin
          state_s    = ST_RINGING;
          ring_cnt_s = 4'd0;
        end else if (min_tick) begin
          snz_cnt_s = snz_cnt_r - 4'd1;
        end else begin
          state_s = ST_SNOOZE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        ring_cnt_s = 4'd0;
        snz_cnt_s  = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ring_cnt_r <= 4'd0;
      snz_cnt_r  <= 4'd0;
    end else begin
      state_r    <= state_s;
      ring_cnt_r <= ring_cnt_s;
      snz_cnt_r  <= snz_cnt_s;
    end
  end

  assign buzzer   = (state_r == ST_RINGING);
  assign snoozing = (state_r == ST_SNOOZE);
  assign state_o  = state_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios followed by
// randomized traffic, all compared against a minute-level behavioural model.
module tb_alarm_controller;

  localparam int SNOOZE_MIN       = 5;
  localparam int RING_TIMEOUT_MIN = 10;

  logic       clk;
  logic       rst_n;
  logic       eq;
  logic       alarm_en;
  logic       min_tick;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       snoozing;
  logic [1:0] state_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Model: mode 0 idle, 1 ringing, 2 snoozing
  int m_mode;
  int m_eq_prev;
  int m_rung;
  int m_snz_left;

  alarm_controller #(
    .SNOOZE_MIN       (SNOOZE_MIN),
    .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eq         (eq),
    .alarm_en   (alarm_en),
    .min_tick   (min_tick),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .buzzer     (buzzer),
    .snoozing   (snoozing),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task model_reset();
    m_mode     = 0;
    m_eq_prev  = 0;
    m_rung     = 0;
    m_snz_left = 0;
  endtask

  // One clock edge of the alarm rules, counting minutes rung and minutes left.
  task model_step(input bit e, input bit en, input bit tk, input bit sz, input bit sp);
    bit match;
    match     = e && (m_eq_prev == 0);
    m_eq_prev = e;
    if (m_mode == 0) begin
      if (match && en) begin
        m_mode = 1;
        m_rung = 0;
      end
    end else if (m_mode == 1) begin
      if (!en || sp) m_mode = 0;
      else if (sz) begin
        m_mode     = 2;
        m_snz_left = SNOOZE_MIN;
      end else if (tk) begin
        m_rung++;
        if (m_rung >= RING_TIMEOUT_MIN) m_mode = 0;
      end
    end else begin
      if (!en || sp) m_mode = 0;
      else if (tk) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_mode = 1;
          m_rung = 0;
        end
      end
    end
  endtask

  task check_outputs(input string tag);
    chk({tag, "_state"}, int'(state_o), m_mode);
    chk({tag, "_buzzer"}, int'(buzzer), (m_mode == 1) ? 1 : 0);
    chk({tag, "_snoozing"}, int'(snoozing), (m_mode == 2) ? 1 : 0);
  endtask

  // Called from the negedge region: drive, clock, model, check, return at negedge.
  task cyc(input bit e, input bit en, input bit tk, input bit sz, input bit sp, input string tag);
    eq = e; alarm_en = en; min_tick = tk; snooze_btn = sz; stop_btn = sp;
    @(posedge clk);
    model_step(e, en, tk, sz, sp);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; eq_rel is eq at release.
  task do_reset(input bit eq_rel, input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_buzzer"}, int'(buzzer), 0);
    chk({tag, "_rst_state"}, int'(state_o), 0);
    chk({tag, "_rst_snoozing"}, int'(snoozing), 0);
    model_reset();
    eq = eq_rel; min_tick = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task start_ring(input string tag);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tag);
    chk({tag, "_ringing"}, int'(buzzer), 1);
  endtask

  initial begin
    int entries;
    int prev_state;
    bit e;
    rst_n = 1'b0; eq = 1'b0; alarm_en = 1'b0; min_tick = 1'b0;
    snooze_btn = 1'b0; stop_btn = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // eq held high for 60 ticks: one entry, timeout after 10 ticks
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold_pre");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "hold_rise");
    chk("hold_latency", int'(buzzer), 1);
    entries = 1;
    prev_state = int'(state_o);
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "hold");
      if (state_o == 2'd1 && prev_state != 1) entries++;
      prev_state = int'(state_o);
      if (i == 9) chk("timeout_state", int'(state_o), 0);
    end
    chk("hold_entries", entries, 1);

    // snooze: 4 ticks stay snoozing, 5th rings again
    start_ring("snz");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "snz_press");
    chk("snz_enter", int'(snoozing), 1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "snz_tick");
    chk("snz_hold4", int'(snoozing), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "snz_tick5");
    chk("snz_rering", int'(buzzer), 1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rering_tick");
    chk("rering_fresh", int'(buzzer), 1);

    // stop beats snooze
    start_ring("both");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "both_press");
    chk("stop_wins", int'(state_o), 0);

    // snooze beats tick, reloads to full length
    start_ring("sztk");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "sztk_press");
    chk("sztk_snooze", int'(state_o), 2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "sztk_tick");
    chk("sztk_noreload", int'(snoozing), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sztk_tick5");
    chk("sztk_rering", int'(buzzer), 1);

    // disarmed: match ignored; disarm in snooze
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dis_pre");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "dis_rise");
    chk("dis_idle", int'(state_o), 0);
    start_ring("dsz");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "dsz_press");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "dsz_drop");
    chk("dsz_idle", int'(state_o), 0);

    // async reset mid-ring, released with eq low then with eq high
    start_ring("rst");
    do_reset(1'b0, "rst_lo");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_lo_after");
    start_ring("rst2");
    do_reset(1'b1, "rst_hi");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hi_after");
    chk("rst_hi_ring", int'(buzzer), 1);

    // randomized traffic
    e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'($urandom_range(0, 1)), "rnd");
        e = eq;
      end else begin
        if ($urandom_range(0, 7) == 0) e = ~e;
        cyc(e,
            1'($urandom_range(0, 15) != 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 11) == 0),
            "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
